// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM status encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM status as reported back to the arbiter each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Saturating 8-bit increment used by status counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Instruction/data requester ports and shared RAM port of the arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // instruction side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // data side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  // status
  logic [7:0] err_cnt;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-requester (instruction/data) arbiter for a single shared RAM port.
// Data requests win unless the instruction side has watched STARVE_LIMIT
// data accesses complete while it waited.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.arb   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  arb_state_t state, nxt, st;
  logic [2:0] starve_cnt;
  logic [7:0] err_cnt;
  logic       dreq, ihit, dhit;

  assign dreq        = bus.dREN | bus.dWEN;
  assign bus.err_cnt = err_cnt;

  // Outputs decode from the registered state; reset forces the IDLE view so
  // a grant in progress is dropped immediately and no hit can escape.
  always_comb begin
    st           = RST ? IDLE : state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    bus.iload    = '0;
    bus.dload    = '0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    case (st)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (bus.iREN && bus.ramstate == ACCESS) begin
          ihit      = 1'b1;
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        // a write takes precedence if both enables are high
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = ~bus.dWEN;
        if (dreq && bus.ramstate == ACCESS) begin
          dhit      = 1'b1;
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

  // Next-state: grant from IDLE, release on hit or requester withdrawal.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (dreq && (!bus.iREN || starve_cnt < LIM)) nxt = DGNT;
        else if (bus.iREN)                           nxt = IGNT;
      end
      IGNT:    if (!bus.iREN || ihit) nxt = IDLE;
      DGNT:    if (!dreq || dhit)     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register plus starvation and error counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      state <= nxt;
      if (!bus.iREN || ihit)
        starve_cnt <= '0;
      else if (dhit && starve_cnt < LIM)
        starve_cnt <= starve_cnt + 3'd1;
      if (bus.ramstate == ERROR)
        err_cnt <= sat_inc8(err_cnt);
    end
  end

endmodule
